pipeline_stall_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS pipeline. Drives the 6-bit stall vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Merges per-stage stall requests and sequences multi-cycle EX operations (mult/div) with an internal down-counter.
- Issues one-cycle pipeline flushes and flags a stuck memory stall with a watchdog.

---
 rtl/pipeline_stall_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl
// ----------------------------------------------------------------------------
// Central stall/flush controller for the 5-stage MIPS pipeline.
//
// Merges per-stage stall requests into one 6-bit stall vector. The vector is
// always a contiguous run of ones starting at bit0, so the deepest requesting
// stage wins. A stage register inserts a bubble where stall[k]=1 and
// stall[k+1]=0.
//
// Multi-cycle EX operations (mult/div) are sequenced with an internal
// down-counter. MEM back-pressure freezes the counter. A flush request clears
// the operation and produces a registered one-cycle flush pulse. A watchdog
// sets a sticky flag when the MEM stall request stays high too long.
//
// Optional feature (macro STALL_STATS_EN):
//   Adds a 32-bit count of cycles with stall[0]=1 and a synchronous clear
//   input. With the macro undefined, neither port nor the counter exists.
//
// Parameters:
//   MC_CNT_W   - width of i_ex_mc_cycles and the multi-cycle counter
//   WDOG_LIMIT - consecutive MEM stall cycles before o_stall_timeout sets
//   WDOG_W     - watchdog counter width, 2**WDOG_W must exceed WDOG_LIMIT
//
// Ports:
//   i_clock             - system clock, rising edge
//   i_reset             - asynchronous, active-high reset
//   i_if_stall_request  - IF stage stall request
//   i_id_stall_request  - ID stage stall request (load-use hazard)
//   i_ex_stall_request  - EX stage stall request (combinational)
//   i_mem_stall_request - MEM stage stall request (bus wait)
//   i_ex_mc_start       - one-cycle pulse, starts a multi-cycle EX operation
//   i_ex_mc_cycles      - extra EX cycles, sampled with i_ex_mc_start
//   i_flush_request     - exception or eret, flush the pipeline
//   o_stall             - bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
//                         bit4 MEM/WB, bit5 WB
//   o_flush             - registered one-cycle flush pulse
//   o_ex_mc_busy        - multi-cycle operation in progress
//   o_ex_mc_done        - registered pulse after the last multi-cycle cycle
//   o_stall_timeout     - sticky watchdog flag
//   i_stats_clear       - (STALL_STATS_EN) synchronous clear of the counter
//   o_stall_cycle_count - (STALL_STATS_EN) cycles with stall[0]=1, wraps
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int MC_CNT_W   = 6,
    parameter int WDOG_LIMIT = 64,
    parameter int WDOG_W     = 7
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_if_stall_request,
    input  logic                i_id_stall_request,
    input  logic                i_ex_stall_request,
    input  logic                i_mem_stall_request,
    input  logic                i_ex_mc_start,
    input  logic [MC_CNT_W-1:0] i_ex_mc_cycles,
    input  logic                i_flush_request,
    output logic [5:0]          o_stall,
    output logic                o_flush,
    output logic                o_ex_mc_busy,
    output logic                o_ex_mc_done,
    output logic                o_stall_timeout
`ifdef STALL_STATS_EN
    ,
    input  logic                i_stats_clear,
    output logic [31:0]         o_stall_cycle_count
`endif
);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMcBusy = 2'd1,
        StFlush  = 2'd2
    } state_t;

    state_t              r_state;
    logic [MC_CNT_W-1:0] r_mc_cnt;
    logic                r_ex_mc_busy;
    logic                r_ex_mc_done;
    logic                r_flush;
    logic [WDOG_W-1:0]   r_wdog_cnt;
    logic                r_stall_timeout;

    logic [5:0]          w_stall;
    logic                w_mc_last;
    logic                w_wdog_sat;
    logic                w_wdog_hit;

    // ------------------------------------------------------------------------
    // Stall vector: combinational, deepest request wins. Forced to zero
    // during the flush cycle so the flushed bubbles advance freely.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stall = 6'b000000;
        if (r_state != StFlush) begin
            if (i_mem_stall_request) begin
                w_stall = 6'b011111;
            end else if (i_ex_stall_request || r_ex_mc_busy) begin
                w_stall = 6'b001111;
            end else if (i_id_stall_request) begin
                w_stall = 6'b000111;
            end else if (i_if_stall_request) begin
                w_stall = 6'b000011;
            end else begin
                w_stall = 6'b000000;
            end
        end
    end

    assign o_stall = w_stall;

    // Counter at 1 means this is the final EX cycle of the operation.
    assign w_mc_last = (r_mc_cnt == MC_CNT_W'(1));

    // ------------------------------------------------------------------------
    // Control FSM. Flush has priority over everything, including a
    // simultaneous i_ex_mc_start, which is discarded.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_mc_cnt     <= '0;
            r_ex_mc_busy <= 1'b0;
            r_ex_mc_done <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_ex_mc_done <= 1'b0;
            r_flush      <= 1'b0;
            if (i_flush_request) begin
                r_state      <= StFlush;
                r_flush      <= 1'b1;
                r_mc_cnt     <= '0;
                r_ex_mc_busy <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_ex_mc_start) begin
                            if (i_ex_mc_cycles != '0) begin
                                r_mc_cnt     <= i_ex_mc_cycles;
                                r_ex_mc_busy <= 1'b1;
                                r_state      <= StMcBusy;
                            end else begin
                                // Zero-length operation completes immediately.
                                r_ex_mc_done <= 1'b1;
                            end
                        end
                    end
                    StMcBusy: begin
                        // MEM back-pressure freezes EX progress.
                        if (!i_mem_stall_request) begin
                            if (w_mc_last) begin
                                r_mc_cnt     <= '0;
                                r_ex_mc_busy <= 1'b0;
                                r_ex_mc_done <= 1'b1;
                                r_state      <= StIdle;
                            end else begin
                                r_mc_cnt <= r_mc_cnt - MC_CNT_W'(1);
                            end
                        end
                    end
                    StFlush: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state      <= StIdle;
                        r_mc_cnt     <= '0;
                        r_ex_mc_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_flush      = r_flush;
    assign o_ex_mc_busy = r_ex_mc_busy;
    assign o_ex_mc_done = r_ex_mc_done;

    // ------------------------------------------------------------------------
    // Watchdog: counts consecutive raw MEM stall cycles and saturates. The
    // flag sets on the edge that completes the WDOG_LIMIT-th cycle and stays
    // set until reset; flushes do not touch it.
    // ------------------------------------------------------------------------
    assign w_wdog_sat = (r_wdog_cnt == {WDOG_W{1'b1}});
    assign w_wdog_hit = i_mem_stall_request &&
                        (r_wdog_cnt >= WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wdog_cnt      <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (!i_mem_stall_request) begin
                r_wdog_cnt <= '0;
            end else if (!w_wdog_sat) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end
            if (w_wdog_hit) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign o_stall_timeout = r_stall_timeout;

`ifdef STALL_STATS_EN
    // ------------------------------------------------------------------------
    // Stall statistics: cycles with the PC held. Clear beats increment.
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_cycle_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycle_count <= '0;
        end else if (i_stats_clear) begin
            r_stall_cycle_count <= '0;
        end else if (w_stall[0]) begin
            r_stall_cycle_count <= r_stall_cycle_count + 32'd1;
        end
    end

    assign o_stall_cycle_count = r_stall_cycle_count;
`endif

endmodule
